multi_source_scheduler: RTL
===========================

MULTI_SOURCE_SCHEDULER -- requirements
Module: multi_source_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- V_ID_WIDTH, 32, vertex/edge id width.
- V_VALUE_WIDTH, 32, vertex value width.
- SRC_NUM, 2, number of input streams (2..8).
- FIFO_DEPTH, 16, entries per source FIFO (power of 2, >=4).
- FULL_MARGIN, 4, prog-full threshold offset.
- HUB_NUM, 32, number of powerlaw hub ids (1..32).
- HUB_TABLE, 1024'b0, HUB_NUM x 32-bit hub ids; entry k in bits [32k+31:32k].
- SI_W = clog2(SRC_NUM), CW = clog2(FIFO_DEPTH)+1, derived.
REQ-002 Ports, one per line: name direction width meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- src_push_flag  in  SRC_NUM  per-source push(1)/pull(0) tag.
- src_v_id  in  SRC_NUM*V_ID_WIDTH  active vertex id; slice s = [(s+1)W-1:sW].
- src_v_value  in  SRC_NUM*V_VALUE_WIDTH  active vertex value.
- src_v_edge  in  SRC_NUM*V_ID_WIDTH  neighbour id.
- src_valid  in  SRC_NUM  write strobe per source.
- src_iter_end  in  SRC_NUM  upstream iteration-end level per source.
- arb_mode  in  2  0 occupancy, 1 round-robin, 2 fixed priority, 3 same as 2.
- next_stage_full  in  1  downstream backpressure.
- src_stage_full  out  SRC_NUM  per-source prog-full.
- push_flag  out  1  tag of issued entry.
- update_v_id  out  V_ID_WIDTH  issued id.
- update_v_value  out  V_VALUE_WIDTH  issued value.
- update_src  out  SI_W  source index of issued entry.
- update_v_valid  out  1  issue strobe.
- iteration_end  out  1  all sources done and drained.
- overflow_err  out  SRC_NUM  sticky per-source write-while-full.

Function
REQ-003 Each source owns one FIFO of FIFO_DEPTH entries of {push_flag, id, value, edge} with a CW-bit count.
REQ-004 Write on src_valid[s]; read on grant; simultaneous write+read leaves count unchanged.
REQ-005 src_valid[s] while count==FIFO_DEPTH and no read: entry dropped, overflow_err[s] set until reset.
REQ-006 src_stage_full[s] = (count >= FIFO_DEPTH-FULL_MARGIN), combinational from count.
REQ-007 Eligible(s) = count[s]!=0 and !next_stage_full; at most one grant per cycle, none when next_stage_full=1.
REQ-008 Mode 0: grant highest count; ties go to the higher source index.
REQ-009 Mode 1: grant first eligible source after last granted index, wrapping SRC_NUM-1 -> 0; pointer resets to SRC_NUM-1.
REQ-010 Mode 2/3: grant lowest eligible index.
REQ-011 arb_mode is sampled every cycle; a change takes effect on the next grant, with no flush.
REQ-012 Outputs are registered; latency is one cycle from grant to update_v_valid; a write at cycle N may issue at cycle N+2 earliest.
REQ-013 Push entry (flag=1) with id all-ones: consumed, update_v_valid=0 that cycle.
REQ-014 Other push entry: update_v_id=edge, update_v_value=value.
REQ-015 Pull entry (flag=0): update_v_id=id; update_v_value=id if edge matches any of the HUB_NUM HUB_TABLE entries, else edge.
REQ-016 Hub compare uses the low V_ID_WIDTH bits of each table entry.
REQ-017 update_src = granted index; push_flag = entry flag.
REQ-018 No grant: all data outputs and update_v_valid registered to 0.
REQ-019 iteration_end registered 1 when all src_iter_end=1, all counts=0 and no grant this cycle; else 0.

Reset
REQ-020 rst=0 asynchronously clears: FIFO pointers and counts, RR pointer (SRC_NUM-1), overflow_err, and all outputs to 0.
REQ-021 Reset mid-operation discards all queued entries; no entry issues in the first cycle after deassertion.
REQ-022 Writes are ignored while rst=0.

Verification
REQ-023 Mode 0, SRC_NUM=2: src0 holds 3 entries, src1 holds 3 -> src1 issues first (tie); when src0=3 and src1=2, src0 issues, update_src=0.
REQ-024 Mode 1, 3 sources each with 2 entries -> grant order 0,1,2,0,1,2; next_stage_full=1 for 2 cycles mid-sequence -> order preserved, no valid.
REQ-025 Pull entry with edge=HUB_TABLE[5], id=77 -> update_v_id=77, update_v_value=77; with edge=9 (not a hub) -> value=9.
REQ-026 Push entry id=all-ones -> count decrements, update_v_valid=0; push entry id=4, edge=8, value=3 -> update_v_id=8, value=3, push_flag=1.
REQ-027 FIFO_DEPTH=16: 17 writes with next_stage_full=1 -> src_stage_full=1 from the 12th write, 17th write dropped, overflow_err[0]=1 until rst.
REQ-028 All src_iter_end=1 with 1 entry queued -> iteration_end=0 until the entry issues, then 1; rst pulse mid-burst -> outputs 0 immediately, counts 0.

Source files
------------

// File: rtl/multi_source_scheduler.sv
// Multi-source vertex scheduler: one FIFO per input stream, a selectable
// arbiter (occupancy / round-robin / fixed priority) and a registered
// issue stage that resolves push/pull entries into vertex updates.
// Ports:
//   clk, rst (async, active-low)
//   src_*            per-source write interface (id/value/edge/flag/valid/iter_end)
//   arb_mode         arbitration policy select
//   next_stage_full  downstream backpressure, blocks all grants
//   src_stage_full   per-source programmable-full (combinational from count)
//   push_flag, update_v_id, update_v_value, update_src, update_v_valid
//                    registered issue outputs
//   iteration_end    registered "all sources done and drained"
//   overflow_err     sticky per-source write-while-full flag
module multi_source_scheduler #(
    parameter int unsigned   V_ID_WIDTH    = 32,
    parameter int unsigned   V_VALUE_WIDTH = 32,
    parameter int unsigned   SRC_NUM       = 2,
    parameter int unsigned   FIFO_DEPTH    = 16,
    parameter int unsigned   FULL_MARGIN   = 4,
    parameter int unsigned   HUB_NUM       = 32,
    parameter logic [1023:0] HUB_TABLE     = 1024'b0,
    localparam int unsigned  SI_W          = $clog2(SRC_NUM),
    localparam int unsigned  CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SRC_NUM-1:0]               src_push_flag,
    input  logic [SRC_NUM*V_ID_WIDTH-1:0]    src_v_id,
    input  logic [SRC_NUM*V_VALUE_WIDTH-1:0] src_v_value,
    input  logic [SRC_NUM*V_ID_WIDTH-1:0]    src_v_edge,
    input  logic [SRC_NUM-1:0]               src_valid,
    input  logic [SRC_NUM-1:0]               src_iter_end,
    input  logic [1:0]                       arb_mode,
    input  logic                             next_stage_full,
    output logic [SRC_NUM-1:0]               src_stage_full,
    output logic                             push_flag,
    output logic [V_ID_WIDTH-1:0]            update_v_id,
    output logic [V_VALUE_WIDTH-1:0]         update_v_value,
    output logic [SI_W-1:0]                  update_src,
    output logic                             update_v_valid,
    output logic                             iteration_end,
    output logic [SRC_NUM-1:0]               overflow_err
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH - FULL_MARGIN);

    // Per-source FIFO views used by the arbiter and issue mux
    logic [CW-1:0]            w_count     [SRC_NUM];
    logic                     w_head_flag [SRC_NUM];
    logic [V_ID_WIDTH-1:0]    w_head_id   [SRC_NUM];
    logic [V_VALUE_WIDTH-1:0] w_head_val  [SRC_NUM];
    logic [V_ID_WIDTH-1:0]    w_head_edge [SRC_NUM];
    logic [SRC_NUM-1:0]       w_rd_en;

    logic                     w_grant_vld;
    logic [SI_W-1:0]          w_grant_idx;
    logic [CW-1:0]            w_best_cnt;
    logic [SI_W-1:0]          w_rr_idx;
    logic [SI_W-1:0]          r_rr_ptr;

    logic                     w_sel_flag;
    logic [V_ID_WIDTH-1:0]    w_sel_id;
    logic [V_VALUE_WIDTH-1:0] w_sel_val;
    logic [V_ID_WIDTH-1:0]    w_sel_edge;
    logic                     w_hub_hit;
    logic                     w_all_empty;

    logic                     r_push_flag;
    logic [V_ID_WIDTH-1:0]    r_id;
    logic [V_VALUE_WIDTH-1:0] r_val;
    logic [SI_W-1:0]          r_src;
    logic                     r_valid;
    logic                     r_iter_end;

    // Source index k steps after ptr, wrapping at SRC_NUM
    function automatic logic [SI_W-1:0] rr_step(input logic [SI_W-1:0] ptr, input int unsigned k);
        int unsigned sum;
        sum = 32'(ptr) + k;
        if (sum >= SRC_NUM) sum = sum - SRC_NUM;
        return SI_W'(sum);
    endfunction

    // Per-source FIFO storage, pointers, occupancy and overflow flag
    for (genvar g = 0; g < SRC_NUM; g++) begin : g_src
        logic                     r_mem_flag [FIFO_DEPTH];
        logic [V_ID_WIDTH-1:0]    r_mem_id   [FIFO_DEPTH];
        logic [V_VALUE_WIDTH-1:0] r_mem_val  [FIFO_DEPTH];
        logic [V_ID_WIDTH-1:0]    r_mem_edge [FIFO_DEPTH];
        logic [AW-1:0]            r_wr_ptr;
        logic [AW-1:0]            r_rd_ptr;
        logic [CW-1:0]            r_count;
        logic                     r_ovf;
        logic                     w_wr;
        logic                     w_drop;

        // A full FIFO still accepts a write when it is being read the same cycle
        assign w_wr   = src_valid[g] && ((r_count != DEPTH_C) || w_rd_en[g]);
        assign w_drop = src_valid[g] && (r_count == DEPTH_C) && !w_rd_en[g];

        always_ff @(posedge clk) begin
            if (rst && w_wr) begin
                r_mem_flag[r_wr_ptr] <= src_push_flag[g];
                r_mem_id[r_wr_ptr]   <= src_v_id[g*V_ID_WIDTH +: V_ID_WIDTH];
                r_mem_val[r_wr_ptr]  <= src_v_value[g*V_VALUE_WIDTH +: V_VALUE_WIDTH];
                r_mem_edge[r_wr_ptr] <= src_v_edge[g*V_ID_WIDTH +: V_ID_WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_wr)       r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_rd_en[g]) r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_wr && !w_rd_en[g])      r_count <= r_count + CW'(1);
                else if (!w_wr && w_rd_en[g]) r_count <= r_count - CW'(1);
                if (w_drop)     r_ovf    <= 1'b1;
            end
        end

        assign w_count[g]        = r_count;
        assign w_head_flag[g]    = r_mem_flag[r_rd_ptr];
        assign w_head_id[g]      = r_mem_id[r_rd_ptr];
        assign w_head_val[g]     = r_mem_val[r_rd_ptr];
        assign w_head_edge[g]    = r_mem_edge[r_rd_ptr];
        assign src_stage_full[g] = (r_count >= FULL_C);
        assign overflow_err[g]   = r_ovf;
    end

    // Arbiter: at most one grant per cycle, none under backpressure
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_best_cnt  = '0;
        w_rr_idx    = '0;
        if (!next_stage_full) begin
            case (arb_mode)
                2'd0: begin
                    // Ascending scan with >= hands ties to the higher index
                    for (int unsigned s = 0; s < SRC_NUM; s++) begin
                        if ((w_count[s] != '0) && (w_count[s] >= w_best_cnt)) begin
                            w_grant_vld = 1'b1;
                            w_grant_idx = SI_W'(s);
                            w_best_cnt  = w_count[s];
                        end
                    end
                end
                2'd1: begin
                    for (int unsigned k = 1; k <= SRC_NUM; k++) begin
                        w_rr_idx = rr_step(r_rr_ptr, k);
                        if (!w_grant_vld && (w_count[w_rr_idx] != '0)) begin
                            w_grant_vld = 1'b1;
                            w_grant_idx = w_rr_idx;
                        end
                    end
                end
                default: begin
                    for (int unsigned s = 0; s < SRC_NUM; s++) begin
                        if (!w_grant_vld && (w_count[s] != '0)) begin
                            w_grant_vld = 1'b1;
                            w_grant_idx = SI_W'(s);
                        end
                    end
                end
            endcase
        end
        w_rd_en = '0;
        if (w_grant_vld) w_rd_en[w_grant_idx] = 1'b1;
    end

    // Round-robin pointer tracks the last granted source in every mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_rr_ptr <= SI_W'(SRC_NUM - 1);
        else if (w_grant_vld) r_rr_ptr <= w_grant_idx;
    end

    // Head of the granted FIFO
    assign w_sel_flag = w_head_flag[w_grant_idx];
    assign w_sel_id   = w_head_id[w_grant_idx];
    assign w_sel_val  = w_head_val[w_grant_idx];
    assign w_sel_edge = w_head_edge[w_grant_idx];

    // Hub lookup on the pulled neighbour id
    always_comb begin
        w_hub_hit = 1'b0;
        for (int unsigned k = 0; k < HUB_NUM; k++) begin
            if (w_sel_edge == V_ID_WIDTH'(HUB_TABLE[32*k +: 32])) w_hub_hit = 1'b1;
        end
    end

    always_comb begin
        w_all_empty = 1'b1;
        for (int unsigned s = 0; s < SRC_NUM; s++) begin
            if (w_count[s] != '0) w_all_empty = 1'b0;
        end
    end

    // Issue register; all-ones push ids are consumed without an update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_push_flag <= 1'b0;
            r_id        <= '0;
            r_val       <= '0;
            r_src       <= '0;
            r_valid     <= 1'b0;
            r_iter_end  <= 1'b0;
        end else begin
            r_push_flag <= 1'b0;
            r_id        <= '0;
            r_val       <= '0;
            r_src       <= '0;
            r_valid     <= 1'b0;
            r_iter_end  <= (&src_iter_end) && w_all_empty && !w_grant_vld;
            if (w_grant_vld) begin
                if (w_sel_flag) begin
                    if (w_sel_id != '1) begin
                        r_push_flag <= 1'b1;
                        r_id        <= w_sel_edge;
                        r_val       <= w_sel_val;
                        r_src       <= w_grant_idx;
                        r_valid     <= 1'b1;
                    end
                end else begin
                    r_id    <= w_sel_id;
                    r_val   <= w_hub_hit ? V_VALUE_WIDTH'(w_sel_id) : V_VALUE_WIDTH'(w_sel_edge);
                    r_src   <= w_grant_idx;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign push_flag      = r_push_flag;
    assign update_v_id    = r_id;
    assign update_v_value = r_val;
    assign update_src     = r_src;
    assign update_v_valid = r_valid;
    assign iteration_end  = r_iter_end;

endmodule
